// File: rtl/result_ascii_emitter.sv
// result_ascii_emitter: binary-to-decimal ASCII streamer (double-dabble), optional newline via RESULT_ASCII_NEWLINE_EN
module result_ascii_emitter #(
  parameter int WIDTH = 64,
  parameter int NDIG  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_char,
  output logic             out_last,
  input  logic             out_ready
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(NDIG);
  localparam int BW = 4 * NDIG;
  typedef enum logic [2:0] {
    IDLE, CONVERT, SKIP, EMIT
`ifdef RESULT_ASCII_NEWLINE_EN
    , NL
`endif
  } state_t;
  state_t         state;
  logic [WIDTH-1:0] shift;
  logic [BW-1:0]  bcd, adj;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic [3:0]     dig;
  assign dig = bcd[{idx, 2'b00} +: 4];
  assign in_ready = state == IDLE;
`ifdef RESULT_ASCII_NEWLINE_EN
  assign out_valid = state == EMIT || state == NL;
  assign out_last  = state == NL;
  assign out_char  = state == EMIT ? 8'h30 + {4'h0, dig} : state == NL ? 8'h0A : 8'h00;
`else
  assign out_valid = state == EMIT;
  assign out_last  = state == EMIT && idx == '0;
  assign out_char  = state == EMIT ? 8'h30 + {4'h0, dig} : 8'h00;
`endif
  // add-3 correction on every nibble that would overflow past 9 after the shift
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDIG; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // control FSM: capture, convert bit-serially, skip leading zeros, stream digits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      shift <= '0;
      bcd   <= '0;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shift <= in_value;
          bcd   <= '0;
          cnt   <= CW'(WIDTH);
          state <= CONVERT;
        end
        CONVERT: begin
          {bcd, shift} <= {adj[BW-2:0], shift, 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= SKIP;
            idx   <= IW'(NDIG - 1);
          end
        end
        SKIP: if (dig == 4'd0 && idx != '0) idx <= idx - 1'b1;
              else state <= EMIT;
        EMIT: if (out_ready) begin
          if (idx != '0) idx <= idx - 1'b1;
`ifdef RESULT_ASCII_NEWLINE_EN
          else state <= NL;
`else
          else state <= IDLE;
`endif
        end
`ifdef RESULT_ASCII_NEWLINE_EN
        NL: if (out_ready) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_ascii_emitter.sv
// tb_result_ascii_emitter: randomized check of result_ascii_emitter against a decimal-string reference model
module tb_result_ascii_emitter;
  localparam int W = 64;
  localparam int ND = 20;
  typedef struct packed {logic [7:0] ch; logic last;} ent_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [W-1:0] in_value = '0;
  logic in_ready, out_valid, out_last;
  logic [7:0] out_char;
  int checks = 0, errors = 0;
  ent_t q[$];
  bit busy = 0, chk_en = 0, ev;
  int t = 0, lat = 0, mode = 0, pc = 0;
  string got = "";

  result_ascii_emitter #(.WIDTH(W), .NDIG(ND)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
    .in_ready(in_ready), .out_valid(out_valid), .out_char(out_char),
    .out_last(out_last), .out_ready(out_ready));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic chk_s(input string n, input string a, input string e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", n, a, e);
    end
  endtask

  function automatic string dec(input logic [W-1:0] v);
    return $sformatf("%0d", v);
  endfunction

  function automatic int lat_of(input logic [W-1:0] v);
    return W + (ND - dec(v).len()) + 1;
  endfunction

  function automatic string with_nl(input string s);
`ifdef RESULT_ASCII_NEWLINE_EN
    return {s, "\n"};
`else
    return s;
`endif
  endfunction

  // reference model: predicts outputs at each negedge, then advances over the coming edge
  always @(negedge clk) begin
    ev = busy && t >= lat && q.size() > 0;
    if (chk_en) begin
      chk("in_ready", in_ready, !busy);
      chk("out_valid", out_valid, ev);
      chk("out_char", out_char, ev ? q[0].ch : 8'h00);
      chk("out_last", out_last, ev ? q[0].last : 1'b0);
    end
    if (!rst_n) begin
      busy = 0;
      q.delete();
      chk_en = 1;
    end else if (!busy) begin
      if (in_valid) begin
        string s;
        s = dec(in_value);
        lat = lat_of(in_value);
        for (int i = 0; i < s.len(); i++) begin
          ent_t e;
          e.ch = s[i];
`ifdef RESULT_ASCII_NEWLINE_EN
          e.last = 1'b0;
`else
          e.last = i == s.len() - 1;
`endif
          q.push_back(e);
        end
`ifdef RESULT_ASCII_NEWLINE_EN
        q.push_back('{8'h0A, 1'b1});
`endif
        busy = 1;
        t = 0;
      end
    end else begin
      t++;
      if (ev && out_ready) begin
        got = $sformatf("%s%c", got, q[0].ch);
        void'(q.pop_front());
        if (q.size() == 0) busy = 0;
      end
    end
  end

  // sink backpressure: always ready, random, or the 1,0,0 pattern
  always @(posedge clk) begin
    #1;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : (pc % 3 == 0);
    pc++;
  end

  task automatic send(input logic [W-1:0] v);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 3000) begin @(posedge clk); #1; n++; end
    if (n >= 3000) chk("send_timeout", 1, 0);
    in_valid = 1;
    in_value = v;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(posedge clk);
    while (busy && n < 3000) begin @(posedge clk); n++; end
    if (n >= 3000) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 3000) begin @(posedge clk); #1; n++; end
    if (n >= 3000) chk("valid_timeout", 1, 0);
  endtask

  task automatic run(input logic [W-1:0] v, input string exp, input string n);
    got = "";
    send(v);
    wait_idle();
    chk_s(n, got, with_nl(exp));
  endtask

  initial begin
    logic [W-1:0] v;
    chk_s("model_0", dec(0), "0");
    chk_s("model_142", dec(142), "142");
    chk_s("model_max", dec('1), "18446744073709551615");
    chk("lat_0", lat_of(0), 84);
    chk("lat_142", lat_of(142), 82);
    chk("lat_max", lat_of('1), 65);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run(0, "0", "str_0");
    run(142, "142", "str_142");
    run('1, "18446744073709551615", "str_max");
    mode = 2;
    got = "";
    send(55123);
    wait_valid();
    in_value = 99;
    in_valid = 1;
    repeat (3) @(posedge clk);
    #1 in_valid = 0;
    wait_idle();
    chk_s("str_55123_stall", got, with_nl("55123"));
    mode = 0;
    got = "";
    send(55123);
    wait_valid();
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk_s("str_abandoned", got, "5");
    run(7, "7", "str_7");
    for (int k = 0; k < 30; k++) begin
      mode = $urandom_range(0, 2);
      v = {$urandom, $urandom} >> $urandom_range(63, 0);
      run(v, dec(v), "str_rand");
    end
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
